// File: rtl/grey_counter.sv
// -----------------------------------------------------------------------------
// grey_counter
//
// Accumulating counter with a Gray-coded output. On every rising clock edge the
// unsigned step `a` is added to an internal WIDTH-bit binary count. The carry
// out of that addition is registered alongside the count. The output `g` is the
// reflected Gray code of the registered count.
//
// Ports (positional order is fixed for legacy instantiations):
//   a      in  WIDTH  unsigned step added to the count on each rising edge
//   clk    in  1      rising-edge clock
//   reset  in  1      synchronous, active-high; clears count and carry
//   g      out WIDTH  Gray code of the registered count (combinational)
//   c_out  out 1      registered carry-out of the most recent update
// -----------------------------------------------------------------------------
module grey_counter #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] g,
    output logic             c_out
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             c_out_q;
    logic             c_out_d;

    // Explicit ripple-carry adder. carry[0] is the carry-in (always 0), and
    // carry[WIDTH] is the carry-out. That carry-out is 1 exactly when
    // cnt_q + a reaches 2^WIDTH.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_adder
            assign sum[gi]     = cnt_q[gi] ^ a[gi] ^ carry[gi];
            assign carry[gi+1] = (cnt_q[gi] & a[gi])
                               | (cnt_q[gi] & carry[gi])
                               | (a[gi] & carry[gi]);
        end
    endgenerate

    // Reset has priority over the addition. The sum wraps modulo 2^WIDTH
    // because only the low WIDTH bits are kept.
    always_comb begin
        cnt_d   = sum;
        c_out_d = carry[WIDTH];
        if (reset) begin
            cnt_d   = '0;
            c_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q   <= cnt_d;
        c_out_q <= c_out_d;
    end

    // Binary to Gray conversion: g = cnt ^ (cnt >> 1). The MSB passes through
    // unchanged. Each lower bit is the XOR of a bit with its upper neighbour.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gray
            if (gi == WIDTH - 1) begin : g_msb
                assign g[gi] = cnt_q[gi];
            end else begin : g_low
                assign g[gi] = cnt_q[gi] ^ cnt_q[gi+1];
            end
        end
    endgenerate

    assign c_out = c_out_q;

endmodule

// File: tb/tb_grey_counter.sv
// -----------------------------------------------------------------------------
// tb_grey_counter
//
// The driver applies (reset, a) at each falling edge. It advances a reference
// model and pushes the expected (g, c_out) into a queue. The monitor pops the
// queue shortly after each rising edge and compares the popped entry with the
// DUT outputs.
//
// The reference model keeps the count as a plain integer, modulo 2^WIDTH. It
// maps the count to a Gray value through a table built by the
// reflect-and-prefix construction.
//
// Some cycles glitch reset and a between edges. The driver then checks that
// the outputs have not moved.
// -----------------------------------------------------------------------------
module tb_grey_counter;

    localparam int WIDTH = 4;
    localparam int MODV  = 1 << WIDTH;

    logic [WIDTH-1:0] a;
    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] g;
    logic             c_out;

    grey_counter #(.WIDTH(WIDTH)) dut (
        .a     (a),
        .clk   (clk),
        .reset (reset),
        .g     (g),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] g;
        logic             c;
        bit               step_one;  // a == 1 without reset: exactly one bit of g must flip
        int               cnt;
    } exp_t;

    exp_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;

    int  gray_tab[MODV];
    int  model_cnt   = 0;
    bit  model_valid = 0;
    bit  driver_done = 0;

    // Reflected Gray table: the sequence for k+1 bits is the k-bit sequence
    // followed by its mirror image with bit k set.
    initial begin
        gray_tab[0] = 0;
        for (int k = 0; k < WIDTH; k++) begin
            for (int i = 0; i < (1 << k); i++) begin
                gray_tab[(1 << k) + i] = gray_tab[(1 << k) - 1 - i] | (1 << k);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Apply one cycle of stimulus and record the expected outcome.
    task automatic drive(input bit rst, input int step, input bit glitch);
        exp_t e;
        int   s;
        @(negedge clk);
        if (glitch && model_valid) begin
            reset = ~rst;
            a     = WIDTH'($urandom);
            #1;
            reset = 1'b1;
            a     = ~a;
            #1;
            check("glitch_g", int'(g), gray_tab[model_cnt]);
            #1;
        end
        reset = rst;
        a     = WIDTH'(step);
        if (rst) begin
            model_cnt = 0;
            e.c       = 1'b0;
        end else begin
            s         = model_cnt + step;
            e.c       = (s >= MODV);
            model_cnt = s % MODV;
        end
        model_valid = 1;
        e.g        = WIDTH'(gray_tab[model_cnt]);
        e.cnt      = model_cnt;
        e.step_one = !rst && step == 1;
        exp_q.push_back(e);
        $display("drive: reset=%0d a=%0d -> expect cnt=%0d g=%b c_out=%0d",
                 rst, step, model_cnt, e.g, e.c);
    endtask

    // Monitor: compare outputs shortly after each rising edge.
    logic [WIDTH-1:0] prev_g;
    initial begin
        exp_t e;
        bit   have_prev = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("g", int'(g), int'(e.g));
                check("c_out", int'(c_out), int'(e.c));
                if (e.step_one && have_prev) begin
                    check("one_bit_change", $countones(g ^ prev_g), 1);
                end
                $display("mon: g=%b c_out=%0d (cnt=%0d)", g, c_out, e.cnt);
                prev_g    = g;
                have_prev = 1;
            end
        end
    end

    initial begin
        a     = '0;
        reset = 1'b0;

        // Reset with a=1, then count 1, 2, 3.
        drive(1, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0);
        // From cnt=3, add 15 twice: both updates carry.
        drive(0, 15, 0);
        drive(0, 15, 0);
        // Full 16-step Gray walk from reset.
        drive(1, 0, 0);
        for (int i = 0; i < 16; i++) drive(0, 1, 0);
        // Hold at cnt=5 with a=0.
        drive(1, 0, 0);
        drive(0, 5, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0);
        // Reset in mid-count from cnt=9, then resume with a=3.
        drive(1, 0, 0);
        drive(0, 9, 0);
        drive(1, 3, 0);
        drive(0, 3, 0);
        drive(0, 3, 0);
        // Glitches between edges must not disturb the outputs.
        for (int i = 0; i < 4; i++) drive(0, 2, 1);
        // Randomised run.
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 15) == 0), int'($urandom_range(0, MODV - 1)),
                  ($urandom_range(0, 3) == 0));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
